// File: rtl/i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_regfile
// Description : Clocked I2C target with a 2**REG_AW x 8 register file.
//               Oversamples SCL/SDA, detects START/STOP, matches a 7-bit
//               address, latches a register pointer and performs
//               auto-incrementing register writes and reads.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1101001,
    parameter int         REG_AW     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              wr_pulse,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int c_depth = 1 << REG_AW;
    localparam logic [REG_AW-1:0] c_ptr_one = {{(REG_AW-1){1'b0}}, 1'b1};

    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_addr     = 4'd1;
    localparam logic [3:0] c_st_addr_ack = 4'd2;
    localparam logic [3:0] c_st_ptr      = 4'd3;
    localparam logic [3:0] c_st_dack     = 4'd4;  // ACK slot after PTR / WDATA bytes
    localparam logic [3:0] c_st_wdata    = 4'd5;
    localparam logic [3:0] c_st_rdata    = 4'd6;
    localparam logic [3:0] c_st_rack     = 4'd7;
    localparam logic [3:0] c_st_ignore   = 4'd8;

    logic              r_scl_s1, r_scl_s2, r_scl_prev;
    logic              r_sda_s1, r_sda_s2, r_sda_prev;
    logic [3:0]        r_state, w_state_nxt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_rw;
    logic              r_ack_phase;   // first SCL fall of the current slot has been seen
    logic [REG_AW-1:0] r_ptr;
    logic [7:0]        r_mem [c_depth];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;
    logic       w_byte_done, w_addr_match, w_wr_fire;
    logic [7:0] w_rd_byte;

    assign w_scl_rise   = ~r_scl_prev &  r_scl_s2;
    assign w_scl_fall   =  r_scl_prev & ~r_scl_s2;
    assign w_start      =  r_sda_prev & ~r_sda_s2 & r_scl_s2;
    assign w_stop       = ~r_sda_prev &  r_sda_s2 & r_scl_s2;
    assign w_byte       = {r_shift[6:0], r_sda_s2};
    assign w_byte_done  = w_scl_rise && (r_bit_cnt == 3'd7);
    assign w_addr_match = (w_byte[7:1] == SLAVE_ADDR);
    assign w_wr_fire    = (r_state == c_st_wdata) && w_byte_done && !w_start && !w_stop;
    // A write landing in the same cycle as a preload must be visible to the read.
    assign w_rd_byte    = w_wr_fire ? w_byte : r_mem[r_ptr];

    // Synchronise the bus lines and keep one cycle of history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_s1   <= scl_in;
            r_scl_s2   <= r_scl_s1;
            r_scl_prev <= r_scl_s2;
            r_sda_s1   <= sda_in;
            r_sda_s2   <= r_sda_s1;
            r_sda_prev <= r_sda_s2;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; bus conditions take priority over any SCL edge.
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = c_st_addr;
        end else if (w_stop) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_addr:     if (w_byte_done) w_state_nxt = w_addr_match ? c_st_addr_ack : c_st_ignore;
                c_st_addr_ack: if (w_scl_fall && r_ack_phase) w_state_nxt = r_rw ? c_st_rdata : c_st_ptr;
                c_st_ptr:      if (w_byte_done) w_state_nxt = c_st_dack;
                c_st_dack:     if (w_scl_fall && r_ack_phase) w_state_nxt = c_st_wdata;
                c_st_wdata:    if (w_byte_done) w_state_nxt = c_st_dack;
                c_st_rdata:    if (w_scl_fall && (r_bit_cnt == 3'd7)) w_state_nxt = c_st_rack;
                c_st_rack: begin
                    if (w_scl_rise && r_sda_s2)            w_state_nxt = c_st_ignore;
                    else if (w_scl_fall && r_ack_phase)    w_state_nxt = c_st_rdata;
                end
                c_st_idle, c_st_ignore: w_state_nxt = r_state;
                default:       w_state_nxt = c_st_idle;
            endcase
        end
    end

    // Busy covers every state reached only through an address match.
    always_comb begin
        busy = 1'b0;
        case (r_state)
            c_st_addr_ack, c_st_ptr, c_st_dack, c_st_wdata, c_st_rdata, c_st_rack: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Shift register, bit counter, pointer, register file and SDA drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            sda_oe      <= 1'b0;
            wr_pulse    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rw        <= 1'b0;
            r_ack_phase <= 1'b0;
            r_ptr       <= '0;
            for (int i = 0; i < c_depth; i++) r_mem[i] <= '0;
        end else begin
            wr_pulse <= 1'b0;
            if (r_state != w_state_nxt) r_ack_phase <= 1'b0;
            if (w_start || w_stop) begin
                r_bit_cnt <= '0;
                sda_oe    <= 1'b0;
            end else begin
                case (r_state)
                    c_st_addr, c_st_ptr, c_st_wdata: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                        if (w_byte_done) begin
                            if (r_state == c_st_addr) r_rw  <= w_byte[0];
                            if (r_state == c_st_ptr)  r_ptr <= w_byte[REG_AW-1:0];
                        end
                        if (w_wr_fire) begin
                            r_mem[r_ptr] <= w_byte;
                            wr_pulse     <= 1'b1;
                            wr_addr      <= r_ptr;
                            wr_data      <= w_byte;
                            r_ptr        <= r_ptr + c_ptr_one;
                        end
                    end
                    c_st_addr_ack, c_st_dack: begin
                        if (w_scl_fall) begin
                            if (!r_ack_phase) begin
                                sda_oe      <= 1'b1;
                                r_ack_phase <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                r_bit_cnt <= '0;
                                if ((r_state == c_st_addr_ack) && r_rw) begin
                                    r_shift <= w_rd_byte;
                                    sda_oe  <= ~w_rd_byte[7];
                                end
                            end
                        end
                    end
                    c_st_rdata: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                sda_oe    <= 1'b0;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                sda_oe    <= ~r_shift[6];
                                r_shift   <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end
                    c_st_rack: begin
                        if (w_scl_rise) begin
                            r_ptr <= r_ptr + c_ptr_one;
                            if (!r_sda_s2) r_ack_phase <= 1'b1;
                        end
                        if (w_scl_fall && r_ack_phase) begin
                            r_shift   <= w_rd_byte;
                            sda_oe    <= ~w_rd_byte[7];
                            r_bit_cnt <= '0;
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_target_regfile
// Description : Self-checking bench for i2c_target_regfile. A bit-banged I2C
//               master drives the bus; writes and read data are scoreboarded.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_regfile;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe, wr_pulse, busy;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    int   checks = 0;
    int   errors = 0;
    wr_t  q_wr[$];
    logic [7:0] q_rd[$];
    wr_t  mon_e;
    logic watch = 1'b0, saw_oe = 1'b0, saw_busy = 1'b0;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_regfile #(.SLAVE_ADDR(7'b1101001), .REG_AW(6)) dut (
        .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
        .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Write scoreboard: every strobe must match the next expected write.
    always @(negedge clk) begin
        if (!rst && wr_pulse === 1'b1) begin
            checks++;
            if (q_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr %0d data %h, expected no write", wr_addr, wr_data);
            end else begin
                mon_e = q_wr.pop_front();
                if (wr_addr !== mon_e.a || wr_data !== mon_e.d) begin
                    errors++;
                    $display("FAIL wr_strobe: got addr %0d data %h, expected addr %0d data %h",
                             wr_addr, wr_data, mon_e.a, mon_e.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (watch) begin
            if (sda_oe !== 1'b0) saw_oe = 1'b1;
            if (busy !== 1'b0)   saw_busy = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic qwait();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl = 1'b1;   qwait();
        sda_m = 1'b0; qwait();
        scl = 1'b0;   qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl = 1'b1;   qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_m = b; qwait();
        scl = 1'b1; qwait();
        s = sda_bus; qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, s);
            d = {d[6:0], s};
        end
        bus_bit(nack, s);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sda_oe !== 1'b0)   begin errors++; $display("FAIL rst_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL rst_wr_pulse: got %b expected 0", wr_pulse); end
        checks++; if (wr_addr !== 6'd0)  begin errors++; $display("FAIL rst_wr_addr: got %h expected 00", wr_addr); end
        checks++; if (wr_data !== 8'd0)  begin errors++; $display("FAIL rst_wr_data: got %h expected 00", wr_data); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst = 1'b0;
        qwait();
    endtask

    task automatic test_write();
        logic ack;
        logic [7:0] bytes [4];
        bytes = '{8'hD2, 8'h05, 8'hA5, 8'h3C};
        q_wr.push_back({6'd5, 8'hA5});
        q_wr.push_back({6'd6, 8'h3C});
        bus_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], ack);
            checks++;
            if (ack !== 1'b1) begin errors++; $display("FAIL write_ack[%0d]: got %b expected 1", i, ack); end
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b expected 1", busy); end
            end
        end
        bus_stop();
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
        checks++; if (q_wr.size() != 0) begin errors++; $display("FAIL write_missing: got %0d pending expected 0", q_wr.size()); end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] d, e;
        // seed reg7 so the final pointer position can be observed
        q_wr.push_back({6'd7, 8'h77});
        bus_start(); write_byte(8'hD2, ack); write_byte(8'h07, ack); write_byte(8'h77, ack); bus_stop();
        bus_start();
        write_byte(8'hD2, ack);
        write_byte(8'h05, ack);
        bus_start();
        write_byte(8'hD3, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_addr_ack: got %b expected 1", ack); end
        q_rd.push_back(8'hA5);
        read_byte(1'b0, d); e = q_rd.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL read_byte0: got %h expected %h", d, e); end
        q_rd.push_back(8'h3C);
        read_byte(1'b1, d); e = q_rd.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL read_byte1: got %h expected %h", d, e); end
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL read_release_after_nack: got %b expected 0", sda_oe); end
        bus_stop();
        // pointer should now be 7
        bus_start();
        write_byte(8'hD3, ack);
        q_rd.push_back(8'h77);
        read_byte(1'b1, d); e = q_rd.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL read_final_ptr: got %h expected %h", d, e); end
        bus_stop();
        checks++; if (q_wr.size() != 0) begin errors++; $display("FAIL read_seed_missing: got %0d pending expected 0", q_wr.size()); end
    endtask

    task automatic test_mismatch();
        logic ack;
        saw_oe = 1'b0; saw_busy = 1'b0; watch = 1'b1;
        bus_start();
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mismatch_addr_ack: got %b expected 0", ack); end
        write_byte(8'h11, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mismatch_data_ack: got %b expected 0", ack); end
        bus_stop();
        watch = 1'b0;
        checks++; if (saw_oe !== 1'b0)   begin errors++; $display("FAIL mismatch_sda_oe: got %b expected 0", saw_oe); end
        checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy: got %b expected 0", saw_busy); end
    endtask

    task automatic test_wrap();
        logic ack;
        logic [7:0] d, e;
        q_wr.push_back({6'd63, 8'h01});
        q_wr.push_back({6'd0,  8'h02});
        bus_start();
        write_byte(8'hD2, ack); write_byte(8'h3F, ack);
        write_byte(8'h01, ack); write_byte(8'h02, ack);
        bus_stop();
        checks++; if (q_wr.size() != 0) begin errors++; $display("FAIL wrap_missing: got %0d pending expected 0", q_wr.size()); end
        bus_start();
        write_byte(8'hD2, ack); write_byte(8'h3F, ack);
        bus_start();
        write_byte(8'hD3, ack);
        q_rd.push_back(8'h01);
        read_byte(1'b0, d); e = q_rd.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL wrap_read63: got %h expected %h", d, e); end
        q_rd.push_back(8'h02);
        read_byte(1'b1, d); e = q_rd.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL wrap_read0: got %h expected %h", d, e); end
        bus_stop();
    endtask

    task automatic test_abort_stop();
        logic ack, s;
        logic [7:0] d, e;
        q_wr.push_back({6'h10, 8'h5A});
        bus_start(); write_byte(8'hD2, ack); write_byte(8'h10, ack); write_byte(8'h5A, ack); bus_stop();
        bus_start(); write_byte(8'hD2, ack); write_byte(8'h10, ack);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
        bus_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        // read without setting the pointer: it must still be 0x10
        bus_start();
        write_byte(8'hD3, ack);
        q_rd.push_back(8'h5A);
        read_byte(1'b1, d); e = q_rd.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL abort_old_value: got %h expected %h", d, e); end
        bus_stop();
    endtask

    task automatic test_reset_mid_read();
        logic ack, s;
        logic [7:0] d, e;
        bus_start();
        write_byte(8'hD2, ack); write_byte(8'h00, ack);
        bus_start();
        write_byte(8'hD3, ack);
        bus_bit(1'b1, s); bus_bit(1'b1, s);
        // reg0 holds 0x02: bit5 is 0, so the target is pulling SDA low now
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL midread_driving: got %b expected 1", sda_oe); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL midread_rst_release: got %b expected 0", sda_oe); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midread_rst_busy: got %b expected 0", busy); end
        rst = 1'b0;
        qwait();
        scl = 1'b1;
        qwait();
        bus_start();
        write_byte(8'hD2, ack); write_byte(8'h00, ack);
        bus_start();
        write_byte(8'hD3, ack);
        q_rd.push_back(8'h00);
        read_byte(1'b1, d); e = q_rd.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL midread_reg0_cleared: got %h expected %h", d, e); end
        bus_stop();
    endtask

    task automatic test_ptr_trunc();
        logic ack;
        q_wr.push_back({6'h07, 8'h99});
        bus_start();
        write_byte(8'hD2, ack);
        write_byte(8'hC7, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL trunc_ptr_ack: got %b expected 1", ack); end
        write_byte(8'h99, ack);
        bus_stop();
        checks++; if (q_wr.size() != 0) begin errors++; $display("FAIL trunc_missing: got %0d pending expected 0", q_wr.size()); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_wrap();
        test_abort_stop();
        test_reset_mid_read();
        test_ptr_trunc();
        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
